fetch_unit: RTL and testbench

//  Instruction fetch stage placed directly upstream of core decode/execute.
//  - Owns the PC and issues in-order requests to the instruction memory (req/gnt + rvalid).
//  - Buffers returned words with their PC in a small queue; presents them to decode via valid/ready.
//  - Accepts branch/jump redirects from execute; flushes the queue and discards in-flight words.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          DROP_W       = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with flush; push on a full FIFO is accepted when a pop happens the same cycle.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  T                             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output T                             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= push_data_i;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, in-order imem requester, decode queue, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int QCW = $clog2(DEPTH+1);
  localparam int OCW = $clog2(MAX_OUTST+1);

  logic [31:0]       pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              fire, rsp_drop, rsp_take, q_pop, credit_ok;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [QCW-1:0]    q_count;
  logic [OCW-1:0]    tag_count;
  logic [31:0]       tag_head;
  fetch_entry_t      q_in, q_head;

  // Outstanding count is the tag FIFO occupancy: one tag per granted, unanswered request.
  assign credit_ok = (int'(q_count) + int'(tag_count)) < DEPTH;
  assign imem_req  = !reset && !redirect_valid && !tag_full && credit_ok;
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;

  assign rsp_drop  = imem_rvalid && (drop_q != '0);
  assign rsp_take  = imem_rvalid && (drop_q == '0) && !tag_empty && !redirect_valid;
  assign q_pop     = !q_empty && dec_ready && !redirect_valid;

  assign q_in.pc   = tag_head;
  assign q_in.inst = imem_rdata;

  fetch_fifo #(.DEPTH(MAX_OUTST), .T(logic [31:0])) u_tag (
    .clk         (clk),
    .rst         (reset),
    .push_i      (fire),
    .push_data_i (pc_q),
    .pop_i       (rsp_take),
    .flush_i     (redirect_valid),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk         (clk),
    .rst         (reset),
    .push_i      (rsp_take),
    .push_data_i (q_in),
    .pop_i       (q_pop),
    .flush_i     (redirect_valid),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign dec_valid = !q_empty;
  assign dec_inst  = q_head.inst;
  assign dec_pc    = q_head.pc;

  // On redirect every in-flight request becomes a drop; a response arriving
  // in the same cycle retires one of them (guarded against a stray rvalid).
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h3;
      drop_d = drop_q + DROP_W'(tag_count)
               - DROP_W'(imem_rvalid && ((drop_q != '0) || !tag_empty));
    end else begin
      if (fire)     pc_d   = next_pc(pc_q);
      if (rsp_drop) drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (q_pop)                   perf_fetched_q <= perf_fetched_q + 32'd1;
      if (dec_ready && !dec_valid) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && tag_empty && (drop_q == '0)));
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_take && q_full && !q_pop));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the imem responder answers each grant one cycle later, in order.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst, dec_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rsp_hold = 1'b0;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model: grants queue their address; one response per cycle unless held.
  always @(posedge clk) begin
    if (reset) pend.delete();
    else if (imem_req && imem_gnt) pend.push_back(imem_addr);
    #1;
    if (!reset && !rsp_hold && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_gnt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b0; rsp_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", dec_pc); end
    n_cmp++; if (dec_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", dec_inst); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int pops;
    do_reset();
    imem_gnt = 1'b1; dec_ready = 1'b1;
    exp = 32'h0; pops = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dec_valid) begin
        n_cmp++;
        if (dec_pc !== exp || dec_inst !== inst_of(exp)) begin
          n_bad++; $display("FAIL stream_word: got pc %h inst %h want pc %h inst %h", dec_pc, dec_inst, exp, inst_of(exp));
        end
        exp = exp + 32'd4; pops++;
      end
      tick();
    end
    n_cmp++; if (pops != 10) begin n_bad++; $display("FAIL stream_rate: got %0d pops want 10", pops); end
  endtask

  task automatic test_backpressure();
    int fires;
    do_reset();
    imem_gnt = 1'b1; dec_ready = 1'b0; fires = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) fires++;
      tick();
    end
    @(negedge clk);
    n_cmp++; if (fires != 4) begin n_bad++; $display("FAIL bp_fires: got %0d want 4", fires); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head: got v%b pc %h want v1 pc 0", dec_valid, dec_pc); end
    tick();
    imem_gnt = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'(i*4) || dec_inst !== inst_of(32'(i*4))) begin
        n_bad++; $display("FAIL bp_drain%0d: got v%b pc %h want v1 pc %h", i, dec_valid, dec_pc, 32'(i*4));
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", dec_valid); end
  endtask

  task automatic test_redirect();
    logic [31:0] got [$];
    do_reset();
    rsp_hold = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_outst_limit: got %b want 0", imem_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; rsp_hold = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_new_req: got req %b addr %h want 1 100", imem_req, imem_addr); end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (dec_valid && dec_ready) got.push_back(dec_pc);
      tick();
    end
    n_cmp++;
    if (got.size() < 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
      n_bad++; $display("FAIL rd_seq: got %0d pops first %h want 100,104", got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] first;
    bit seen;
    do_reset();
    imem_gnt = 1'b1; dec_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8) begin n_bad++; $display("FAIL col_pre: got v%b pc %h want v1 pc 8", dec_valid, dec_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd2) begin n_bad++; $display("FAIL col_perf_pre: got %0d want 2", perf_fetched); end
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL col_flush: got %b want 0", dec_valid); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL col_addr: got %h want 200", imem_addr); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd2) begin n_bad++; $display("FAIL col_perf_nopop: got %0d want 2", perf_fetched); end
`endif
    seen = 1'b0; first = '0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (dec_valid && !seen) begin seen = 1'b1; first = dec_pc; end
      tick();
    end
    n_cmp++; if (!seen || first !== 32'h200) begin n_bad++; $display("FAIL col_first: got seen %b pc %h want 200", seen, first); end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] got [$];
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0;
    do_reset();
    dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin
        n_bad++; $display("FAIL gs_hold%0d: got req %b addr %h want 1 fffffff8", c, imem_req, imem_addr);
      end
      tick();
    end
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin
        n_bad++; $display("FAIL gs_addr%0d: got req %b addr %h want 1 %h", i, imem_req, imem_addr, exp_a[i]);
      end
      if (dec_valid && dec_ready) got.push_back(dec_pc);
      tick();
    end
    imem_gnt = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dec_valid && dec_ready) got.push_back(dec_pc);
      tick();
    end
    n_cmp++;
    if (got.size() != 3) begin n_bad++; $display("FAIL gs_count: got %0d want 3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== exp_a[i]) begin n_bad++; $display("FAIL gs_pc%0d: got %h want %h", i, got[i], exp_a[i]); end
      end
    end
  endtask

  task automatic test_perf_reset();
    do_reset();
    imem_gnt = 1'b1; dec_ready = 1'b0;
    repeat (3) tick();
    imem_gnt = 1'b0;
    tick();
    dec_ready = 1'b1;
    repeat (5) tick();
    dec_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL pr_drained: got %b want 0", dec_valid); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd3) begin n_bad++; $display("FAIL pr_fetched: got %0d want 3", perf_fetched); end
    n_cmp++; if (perf_stall !== 32'd2) begin n_bad++; $display("FAIL pr_stall: got %0d want 2", perf_stall); end
`endif
    imem_gnt = 1'b1; dec_ready = 1'b1;
    tick();
    repeat (4) tick();
    #2;
    n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL pr_busy: got %b want 1", dec_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL pr_async: got v%b req %b want 0 0", dec_valid, imem_req); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_bad++; $display("FAIL pr_async_pc: got %h want 0", dec_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin n_bad++; $display("FAIL pr_perf_clr: got %0d %0d want 0 0", perf_fetched, perf_stall); end
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_bad++; $display("FAIL pr_restart: got v%b pc %h want v1 pc 0", dec_valid, dec_pc); end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_gnt_stall();
    test_perf_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
